mem_arbiter: RTL and testbench

- Shares one 64-bit memory port between the instruction fetch unit and the load/store unit.
- Sits between fetch and decode/LSU on one side and the memory/cache port on the other.
- Single outstanding transaction, fixed data-side priority, with an optional anti-starvation guard for fetch.
- Fetch-side signals are wired directly to the existing fetch interface; the fetch unit itself is unchanged.

---
 rtl/raisin64_mem_pkg.sv | 22 ++
 rtl/mem_arb_starve_ctr.sv | 48 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/raisin64_mem_pkg.sv
// ============================================================================
// Module : raisin64_mem_pkg
// Brief  : Shared widths and arbiter state encoding for the memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package raisin64_mem_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
// ============================================================================
// Module : mem_arb_starve_ctr
// Brief  : Saturating count of back-to-back data grants made while fetch was
//          waiting. Once the count reaches MAX_DSTREAK and fetch is eligible,
//          force_i tells the arbiter to grant fetch ahead of data.
// Ports  : clk, rst_n (async, active-low)
//          i_elig  - fetch eligible this cycle
//          d_grant - arbiter grants data this cycle
//          i_grant - arbiter grants fetch this cycle
//          force_i - override: grant fetch even if data is requesting
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_starve_ctr #(
  parameter int MAX_DSTREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_elig,
  input  logic d_grant,
  input  logic i_grant,
  output logic force_i
);

  localparam int          C_CW  = $clog2(MAX_DSTREAK + 1);
  localparam logic [C_CW-1:0] C_MAX = C_CW'(MAX_DSTREAK);

  logic [C_CW-1:0] r_cnt;
  logic            w_sat;

  assign w_sat   = (r_cnt == C_MAX);
  assign force_i = w_sat & i_elig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_grant) begin
      r_cnt <= '0;
    end else if (d_grant && i_elig && !w_sat) begin
      // Saturate rather than wrap so the override cannot be lost.
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Shares one memory port between instruction fetch and the
//          load/store unit. One transaction outstanding at a time, data side
//          has fixed priority. Build macro MEM_ARB_STARVE_GUARD_EN adds a
//          streak guard that lets fetch in after MAX_DSTREAK data grants.
// Ports  : clk, rst_n (async, active-low)
//          imem_*     - fetch request / one-cycle response pulse
//          fetch_flush- drop the in-flight fetch response (redirect)
//          dmem_*     - LSU request (held until dmem_ack) / completion pulse
//          mem_*      - downstream port; mem_req held until mem_ack
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import raisin64_mem_pkg::*;
#(
  parameter int AW          = ADDR_W,
  parameter int DW          = DATA_W,
  parameter int MAX_DSTREAK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  // fetch side
  input  logic [AW-1:0]   imem_addr,
  input  logic            imem_addr_valid,
  output logic [DW-1:0]   imem_data,
  output logic            imem_data_valid,
  input  logic            fetch_flush,
  // data side
  input  logic [AW-1:0]   dmem_addr,
  input  logic [DW-1:0]   dmem_wdata,
  input  logic            dmem_we,
  input  logic [DW/8-1:0] dmem_be,
  input  logic            dmem_req,
  output logic [DW-1:0]   dmem_rdata,
  output logic            dmem_ack,
  // memory side
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic            mem_req,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_I_BUSY = I_BUSY;
  localparam logic [1:0] ST_D_BUSY = D_BUSY;

  logic [1:0] r_state;
  logic       r_flush_pend;

  logic w_i_elig;
  logic w_d_elig;
  logic w_force_i;
  logic w_idle;
  logic w_grant_i;
  logic w_grant_d;
  logic w_done;

  // A requester whose response pulse is high this cycle is still showing the
  // request that just completed, so it must not be re-granted.
  assign w_i_elig = imem_addr_valid & ~imem_data_valid;
  assign w_d_elig = dmem_req & ~dmem_ack;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_grant_d = w_idle & w_d_elig & ~w_force_i;
  assign w_grant_i = w_idle & w_i_elig & (w_force_i | ~w_d_elig);
  assign w_done    = ~w_idle & mem_req & mem_ack;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .MAX_DSTREAK (MAX_DSTREAK)
  ) u_starve_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_elig  (w_i_elig),
    .d_grant (w_grant_d),
    .i_grant (w_grant_i),
    .force_i (w_force_i)
  );
`else
  logic w_unused_cfg;
  assign w_force_i    = 1'b0;
  assign w_unused_cfg = ^MAX_DSTREAK;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_flush_pend    <= 1'b0;
      imem_data       <= '0;
      imem_data_valid <= 1'b0;
      dmem_rdata      <= '0;
      dmem_ack        <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_we          <= 1'b0;
      mem_be          <= '0;
      mem_req         <= 1'b0;
    end else begin
      imem_data_valid <= 1'b0;
      dmem_ack        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            mem_addr  <= dmem_addr;
            mem_wdata <= dmem_wdata;
            mem_we    <= dmem_we;
            mem_be    <= dmem_be;
            mem_req   <= 1'b1;
            r_state   <= ST_D_BUSY;
          end else if (w_grant_i) begin
            mem_addr  <= imem_addr;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '1;
            mem_req   <= 1'b1;
            r_state   <= ST_I_BUSY;
          end
        end
        ST_I_BUSY: begin
          if (w_done) begin
            mem_req      <= 1'b0;
            r_state      <= ST_IDLE;
            r_flush_pend <= 1'b0;
            // A flush seen in the completion cycle itself also kills it.
            if (!(r_flush_pend || fetch_flush)) begin
              imem_data       <= mem_rdata;
              imem_data_valid <= 1'b1;
            end
          end else if (fetch_flush) begin
            r_flush_pend <= 1'b1;
          end
        end
        ST_D_BUSY: begin
          if (w_done) begin
            mem_req    <= 1'b0;
            r_state    <= ST_IDLE;
            dmem_rdata <= mem_rdata;
            dmem_ack   <= 1'b1;
          end
        end
        default: begin
          mem_req <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Self-checking bench for mem_arbiter: directed scenarios followed
//          by randomized traffic, all compared against a transaction-level
//          reference model of the arbitration rules.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int C_MAX = 4;

  logic        clk;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic        imem_addr_valid;
  logic [63:0] imem_data;
  logic        imem_data_valid;
  logic        fetch_flush;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_we;
  logic [7:0]  dmem_be;
  logic        dmem_req;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_be;
  logic        mem_req;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  mem_arbiter #(.AW(64), .DW(64), .MAX_DSTREAK(C_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
    .imem_data(imem_data), .imem_data_valid(imem_data_valid),
    .fetch_flush(fetch_flush),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_req(dmem_req),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_be(mem_be), .mem_req(mem_req),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act,
                          input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = no transaction open, 1 = fetch transaction, 2 = data transaction
  int          m_owner;
  bit          m_flushed;
  int          m_streak;
  logic [63:0] e_imem_data, e_dmem_rdata, e_mem_addr, e_mem_wdata;
  logic        e_ivalid, e_dack, e_mem_we, e_mem_req;
  logic [7:0]  e_mem_be;

  task automatic model_reset();
    m_owner = 0; m_flushed = 0; m_streak = 0;
    e_imem_data = '0; e_dmem_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0;
    e_ivalid = 0; e_dack = 0; e_mem_we = 0; e_mem_req = 0; e_mem_be = '0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit fetch_ok, data_ok, pick_i, guard;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fetch_ok = imem_addr_valid && !e_ivalid;
    data_ok  = dmem_req && !e_dack;
    e_ivalid = 0;
    e_dack   = 0;
    if (m_owner == 0) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      guard = (m_streak == C_MAX) && fetch_ok;
`else
      guard = 0;
`endif
      pick_i = fetch_ok && (guard || !data_ok);
      if (data_ok && !pick_i) begin
        if (fetch_ok && m_streak < C_MAX) m_streak++;
        m_owner = 2;
        e_mem_addr = dmem_addr; e_mem_wdata = dmem_wdata;
        e_mem_we = dmem_we; e_mem_be = dmem_be; e_mem_req = 1;
      end else if (pick_i) begin
        m_streak = 0;
        m_owner = 1;
        e_mem_addr = imem_addr; e_mem_wdata = '0;
        e_mem_we = 0; e_mem_be = 8'hFF; e_mem_req = 1;
      end
    end else if (mem_ack) begin
      if (m_owner == 2) begin
        e_dmem_rdata = mem_rdata;
        e_dack = 1;
      end else if (!(m_flushed || fetch_flush)) begin
        e_imem_data = mem_rdata;
        e_ivalid = 1;
      end
      m_owner = 0; m_flushed = 0; e_mem_req = 0;
    end else if (m_owner == 1 && fetch_flush) begin
      m_flushed = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("imem_data",  imem_data,       e_imem_data);
    check_eq("imem_valid", imem_data_valid, e_ivalid);
    check_eq("dmem_rdata", dmem_rdata,      e_dmem_rdata);
    check_eq("dmem_ack",   dmem_ack,        e_dack);
    check_eq("mem_addr",   mem_addr,        e_mem_addr);
    check_eq("mem_wdata",  mem_wdata,       e_mem_wdata);
    check_eq("mem_we",     mem_we,          e_mem_we);
    check_eq("mem_be",     mem_be,          e_mem_be);
    check_eq("mem_req",    mem_req,         e_mem_req);
    check_eq("pulse_excl", imem_data_valid & dmem_ack, 0);
  endtask

  // Inputs are applied at the falling edge; outputs are checked at the next
  // falling edge, well away from the rising edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic inputs_idle();
    imem_addr = '0; imem_addr_valid = 0; fetch_flush = 0;
    dmem_addr = '0; dmem_wdata = '0; dmem_we = 0; dmem_be = '0; dmem_req = 0;
    mem_rdata = '0; mem_ack = 0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  bit lsu_busy;

  initial begin
    inputs_idle();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    check_eq("rst_mem_req", mem_req, 0);
    rst_n = 1;
    tick();

    // Fetch only, zero-wait ack.
    imem_addr = 64'h40; imem_addr_valid = 1;
    mem_ack = 1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    tick();
    check_eq("f_we", mem_we, 0);
    check_eq("f_be", mem_be, 8'hFF);
    imem_addr_valid = 0;
    tick();
    check_eq("f_valid", imem_data_valid, 1);
    check_eq("f_data", imem_data, 64'hDEAD_BEEF_0000_0001);
    mem_ack = 0;
    tick();
    check_eq("f_pulse_end", imem_data_valid, 0);

    // Data and fetch together: data first.
    dmem_req = 1; dmem_we = 1; dmem_addr = 64'h100; dmem_be = 8'h0F;
    dmem_wdata = 64'h1234; imem_addr = 64'h80; imem_addr_valid = 1;
    tick();
    check_eq("d_first_addr", mem_addr, 64'h100);
    check_eq("d_first_we", mem_we, 1);
    check_eq("d_first_be", mem_be, 8'h0F);
    mem_ack = 1; mem_rdata = 64'h5555;
    tick();
    check_eq("d_ack", dmem_ack, 1);
    dmem_req = 0; mem_ack = 0;
    tick();
    check_eq("i_after_d", mem_addr, 64'h80);
    imem_addr_valid = 0; mem_ack = 1; mem_rdata = 64'hAAAA;
    tick();
    mem_ack = 0;
    tick();

    // Ack delayed 5 cycles while dmem_addr toggles.
    dmem_req = 1; dmem_we = 0; dmem_addr = 64'h200;
    tick();
    for (int k = 0; k < 5; k++) begin
      dmem_addr = dmem_addr ^ 64'hFF;
      tick();
      check_eq("hold_req", mem_req, 1);
      check_eq("hold_addr", mem_addr, 64'h200);
    end
    mem_ack = 1; mem_rdata = 64'h7777;
    tick();
    check_eq("dly_ack", dmem_ack, 1);
    dmem_req = 0; mem_ack = 0;
    tick();
    check_eq("dly_ack_len", dmem_ack, 0);

    // Flush during a fetch: response suppressed, data held.
    imem_addr = 64'h300; imem_addr_valid = 1;
    tick();
    imem_addr_valid = 0; fetch_flush = 1;
    tick();
    fetch_flush = 0;
    tick(); tick();
    mem_ack = 1; mem_rdata = 64'hBAD0;
    tick();
    check_eq("flush_valid", imem_data_valid, 0);
    check_eq("flush_data", imem_data, 64'hAAAA);
    mem_ack = 0; imem_addr = 64'h308; imem_addr_valid = 1;
    tick();
    imem_addr_valid = 0; mem_ack = 1; mem_rdata = 64'h600D;
    tick();
    check_eq("post_flush_valid", imem_data_valid, 1);
    check_eq("post_flush_data", imem_data, 64'h600D);
    mem_ack = 0;
    tick();

    // Reset in the middle of a transaction.
    imem_addr = 64'h400; imem_addr_valid = 1;
    tick();
    imem_addr_valid = 0;
    #2 rst_n = 0;
    #1 check_eq("rst_drop_req", mem_req, 0);
    model_reset();
    mem_ack = 1;
    tick();
    rst_n = 1;
    tick();
    check_eq("rst_no_ivalid", imem_data_valid, 0);
    check_eq("rst_no_dack", dmem_ack, 0);
    mem_ack = 0;
    tick();

    // Randomized traffic.
    lsu_busy = 0;
    for (int c = 0; c < 3000; c++) begin
      imem_addr       = rnd64();
      imem_addr_valid = ($urandom_range(0, 1) == 1);
      fetch_flush     = ($urandom_range(0, 9) == 0);
      dmem_addr       = rnd64();
      dmem_wdata      = rnd64();
      dmem_we         = $urandom_range(0, 1);
      dmem_be         = 8'($urandom);
      if (lsu_busy && e_dack) lsu_busy = ($urandom_range(0, 1) == 1);
      else if (!lsu_busy) lsu_busy = ($urandom_range(0, 9) < 4);
      dmem_req  = lsu_busy;
      mem_ack   = ($urandom_range(0, 9) < 4);
      mem_rdata = rnd64();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
